// File: rtl/jmb_window_pkg.sv
// Shared constants and helpers for the 9x9 window blocks.
// Latency: none (package only).
// Backpressure: not applicable.
//
// KERNEL/TAPS describe the square window. sum_width() gives the exact width of
// an 81-tap unsigned sum. tap() gives the LSB offset of tap (r,c) inside the
// flattened, row-major window bus (w00 at the LSBs).
package jmb_window_pkg;

  localparam int KERNEL = 9;
  localparam int TAPS   = KERNEL * KERNEL;

  // 81 * (2^pw - 1) < 2^(pw+7), so seven extra bits hold any window sum.
  function automatic int sum_width(input int pw);
    return pw + 7;
  endfunction

  function automatic int tap(input int r, input int c, input int pw);
    return (r * KERNEL + c) * pw;
  endfunction

endpackage

// File: rtl/jmb_add3_reg.sv
// Registered 3-input unsigned adder used to build the box-sum tree.
// Latency: 1 cycle from inputs to sum_o; free-running, no enable.
// Backpressure: none; a new sum is captured on every clock edge.
//
// Ports:
//   clk_i, rst_n_i     clock and asynchronous active-low reset
//   a_i, b_i, c_i      IN_W-bit unsigned addends (zero-extended)
//   sum_o              OUT_W-bit registered sum
module jmb_add3_reg #(
  parameter int IN_W  = 8,
  parameter int OUT_W = IN_W + 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  b_i,
  input  logic [IN_W-1:0]  c_i,
  output logic [OUT_W-1:0] sum_o
);

  logic [OUT_W-1:0] sum_d;
  logic [OUT_W-1:0] sum_q;

  // OUT_W may be narrower than IN_W+2 at the final stage; the caller
  // guarantees the real operand range still fits.
  always_comb begin
    sum_d = OUT_W'(a_i) + OUT_W'(b_i) + OUT_W'(c_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/jmb_9x9_box_sum.sv
// Sums the 81 taps of a 9x9 sliding window and flags fully-inside windows.
// Latency: 5 cycles from the enable of a pixel to its sum (4 from taps).
// Backpressure: none; enable gaps become bubbles with sum_valid low.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   enable           one pixel accepted per high cycle (same strobe as the
//                    window generator, whose taps lag enable by one cycle)
//   window           81 flattened taps, w00 at the LSBs, row-major
//   sum_out          unsigned window sum
//   sum_valid        sum_out belongs to a window lying fully inside the image
//   centre_row/col   coordinates of the window centre
//   frame_done       pulses with the last valid sum of the frame
module jmb_9x9_box_sum
  import jmb_window_pkg::*;
#(
  parameter int  pixel_width  = 8,
  parameter int  image_width  = 10,
  parameter int  image_height = 10,
  localparam int SUM_W        = sum_width(pixel_width),
  localparam int ROW_W        = $clog2(image_height),
  localparam int COL_W        = $clog2(image_width)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [TAPS*pixel_width-1:0] window,
  output logic [SUM_W-1:0]            sum_out,
  output logic                        sum_valid,
  output logic [ROW_W-1:0]            centre_row,
  output logic [COL_W-1:0]            centre_col,
  output logic                        frame_done
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(image_height - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(image_width - 1);
  localparam int               NSTAGE   = 5;

  typedef struct packed {
    logic             vld;
    logic             last;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tag_t;

  // ---------------------------------------------------------------------
  // Raster position of the pixel being accepted this cycle.
  // ---------------------------------------------------------------------
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (enable) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // ---------------------------------------------------------------------
  // Tag pipeline. Stage 0 is captured with the enable, one cycle before the
  // taps appear, then it rides alongside the four adder stages.
  // A window is fully inside once at least 8 rows and 8 columns precede
  // the newest pixel; the centre sits 4 back in each direction.
  // ---------------------------------------------------------------------
  tag_t tag_d;
  tag_t tag_q [NSTAGE];

  always_comb begin
    tag_d      = '0;
    tag_d.vld  = enable && (row_q >= ROW_W'(KERNEL - 1)) && (col_q >= COL_W'(KERNEL - 1));
    tag_d.last = (row_q == ROW_LAST) && (col_q == COL_LAST);
    tag_d.row  = row_q - ROW_W'(KERNEL / 2);
    tag_d.col  = col_q - COL_W'(KERNEL / 2);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTAGE; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < NSTAGE; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Adder tree: 27 triples -> 9 row sums -> 3 band sums -> total.
  // ---------------------------------------------------------------------
  logic [pixel_width+1:0] s1 [27];
  logic [pixel_width+3:0] s2 [9];
  logic [pixel_width+5:0] s3 [3];
  logic [SUM_W-1:0]       s4;

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar g = 0; g < 3; g++) begin : g_trip
      jmb_add3_reg #(
        .IN_W  (pixel_width),
        .OUT_W (pixel_width + 2)
      ) u_s1 (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .a_i     (window[tap(r, 3*g,     pixel_width) +: pixel_width]),
        .b_i     (window[tap(r, 3*g + 1, pixel_width) +: pixel_width]),
        .c_i     (window[tap(r, 3*g + 2, pixel_width) +: pixel_width]),
        .sum_o   (s1[3*r + g])
      );
    end

    jmb_add3_reg #(
      .IN_W  (pixel_width + 2),
      .OUT_W (pixel_width + 4)
    ) u_s2 (
      .clk_i   (clock),
      .rst_n_i (reset_n),
      .a_i     (s1[3*r]),
      .b_i     (s1[3*r + 1]),
      .c_i     (s1[3*r + 2]),
      .sum_o   (s2[r])
    );
  end

  for (genvar k = 0; k < 3; k++) begin : g_band
    jmb_add3_reg #(
      .IN_W  (pixel_width + 4),
      .OUT_W (pixel_width + 6)
    ) u_s3 (
      .clk_i   (clock),
      .rst_n_i (reset_n),
      .a_i     (s2[3*k]),
      .b_i     (s2[3*k + 1]),
      .c_i     (s2[3*k + 2]),
      .sum_o   (s3[k])
    );
  end

  // Three band sums can reach 3*(2^(pw+6)-1) in principle, but the true
  // 81-tap total always fits SUM_W, so the narrower output is exact.
  jmb_add3_reg #(
    .IN_W  (pixel_width + 6),
    .OUT_W (SUM_W)
  ) u_s4 (
    .clk_i   (clock),
    .rst_n_i (reset_n),
    .a_i     (s3[0]),
    .b_i     (s3[1]),
    .c_i     (s3[2]),
    .sum_o   (s4)
  );

  assign sum_out    = s4;
  assign sum_valid  = tag_q[NSTAGE-1].vld;
  assign centre_row = tag_q[NSTAGE-1].row;
  assign centre_col = tag_q[NSTAGE-1].col;
  assign frame_done = tag_q[NSTAGE-1].vld && tag_q[NSTAGE-1].last;

endmodule

// File: doc/jmb_9x9_box_sum.md
Name: jmb_9x9_box_sum

Overview:
- Downstream consumer of the 9x9 sliding-window generator. Both blocks share the same pixel stream and enable.
- Sums all 81 window taps through a fixed 4-stage pipelined adder tree.
- Tracks raster position with row/column counters, so only windows lying fully inside the image are flagged valid.
- Outputs the box sum plus the window-centre coordinates. This feeds box-blur, mean and threshold stages.

Parameters:
- pixel_width, 8, bits per pixel.
- image_width, 10, pixels per line; must be >= 9.
- image_height, 10, lines per frame; must be >= 9.
- SUM_W (localparam), pixel_width+7, output sum width. 81*(2^pw - 1) < 2^(pw+7).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  same strobe that advances the window generator; one pixel accepted per high cycle.
- window  in  81*pixel_width  flattened taps; w00 at LSBs, row-major, w88 at MSBs.
- sum_out  out  SUM_W  unsigned sum of the 81 taps.
- sum_valid  out  1  sum_out corresponds to a fully-inside window.
- centre_row  out  clog2(image_height)  row of the window centre.
- centre_col  out  clog2(image_width)  column of the window centre.
- frame_done  out  1  one-cycle pulse with the last valid sum of a frame.

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low. Asserting it clears all counters, pipeline registers and valid tags.
- Reset values: every output is 0 while reset is asserted and at the first edge after release.
- Window timing: the window generator registers on enable, so taps reflect pixel P (accepted in cycle t) during cycle t+1.
- Position counters: col and row identify the pixel accepted on each enable.
  - col increments on enable and wraps at image_width-1 to 0; row increments on that wrap.
  - row wraps at image_height-1 to 0. Enable low leaves both counters unchanged.
- Tag capture: cycle t (enable=1) registers tag_v = (row>=8 && col>=8), plus centre = (row-4, col-4) and last = (row==H-1 && col==W-1).
- Pipeline: free-running, no stall. The tag advances alongside the data.
  - S1 (end of t+1): 27 sums of 3 taps, width pw+2.
  - S2: 9 row sums, width pw+4.
  - S3: 3 sums of 3 row sums, width pw+6.
  - S4: total, SUM_W.
  - Outputs are visible in cycle t+5 (latency 5 from enable, 4 from tap presentation).
- sum_valid is high for exactly one cycle per qualifying enable. Back-to-back enables give back-to-back valids.
- Enable gaps: gaps insert bubbles (sum_valid=0). sum_out may change during bubbles but is don't-care.
- frame_done equals sum_valid && last tag, i.e. position (H-1, W-1).
- Arithmetic: all additions are unsigned and zero-extended; no saturation is needed because the widths are exact.
- Frame rollover: the next frame starts at (0,0) with no idle cycle required. Line and frame edges never produce valid tags.
- Reset mid-frame: in-flight tags are dropped, with no spurious valid or frame_done. Counters restart at (0,0) on the first enable after release.
- Simultaneous events: enable together with the col and row wrap updates both counters in the same edge.

Decomposition:
- Shared package jmb_window_pkg holds:
  - KERNEL=9, TAPS=81.
  - A function sum_width(pw) = pw+7.
  - A tap-index helper tap(r,c) returning the base bit offset (r*9+c)*pixel_width.
- One sub-module: jmb_add3_reg, a parameterised registered 3-input unsigned adder with async active-low reset.
  - Instantiated 27+9+3+1 times (the last as a 3-input adder fed 0 in one input, or a 3-into-1 of S3).
- Counters and tag pipeline stay in the top module.

Test Plan:
1. Reset held, then ramp stimulus: data = r*10+c+1 for a 10x10 image, enable always high. First sum_valid arrives 5 cycles after the enable of pixel (8,8), with sum_out=3645 and centre=(4,4). It is followed by 3726 (4,5); then, after the line gap, 4455 (5,4) and 4536 (5,5) with frame_done=1. Exactly 4 valids per frame.
2. All pixels 255: every valid sum_out = 20655 (0x50AF); no overflow in 15 bits.
3. Enable toggling 1,0,1,0 with the ramp: same 4 sums and centres. Each valid comes exactly 5 cycles after its enable; bubbles have sum_valid=0.
4. Two consecutive frames, no gap: second-frame sums are identical to the first. frame_done pulses twice, with no valid during rows 0-7 of frame 2.
5. reset_n pulsed low mid-row 8 with valids in flight: outputs drop to 0 asynchronously and no valid appears for the aborted frame. A restarted frame reproduces scenario 1 exactly.
6. Parameter sweep image_width=12, image_height=9: 4 valids on row 8 only (centre_row=4, cols 4..7). frame_done accompanies centre (4,7).
